mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Control-step sequencer for the single-bus CPU datapath. It drives every datapath control input: bus source select, register enables, ALU opcode, GP address, PC increment and MDR read. It walks instruction fetch (T0–T2) and then the execute steps for register-register ALU, MUL, DIV, NOP and HALT instructions. It replaces the hand-written per-state stimulus currently used to exercise the datapath, and connects port-for-port to the datapath control inputs.

## Interface
Parameters:
- OPW, 5, opcode field width (IR[31:27]).
- CNTW, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- clear  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  level/pulse; sampled in IDLE to begin fetching.
- mem_ready  in  1  memory read data valid on Mdatain this cycle.
- ir  in  32  IR contents from datapath.
- BusDataSelect  out  5  bus source: 0rrrr = GP reg r; 10010 = Zhigh; 10011 = Zlow; 10100 = PC; 10101 = MDR.
- GP_addr  out  4  GP register write address.
- ALU_op  out  4  ADD 0000, SUB 0001, AND 0010, OR 0011, MUL 0101, DIV 0110; default 0000.
- e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP  out  1 each  register load enables.
- incPC  out  1  ALU computes PC+1 this cycle.
- MDR_read  out  1  MDR selects Mdatain.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse on HALT execution.
- illegal  out  1  sticky; set on undefined opcode, cleared only by reset.
- instr_count  out  CNTW  retired instructions, wraps modulo 2^CNTW.

## Operation
- Decode fields: op = ir[31:27], Ra = ir[26:23], Rb = ir[22:19], Rc = ir[18:15].
- Opcodes:
  - ADD 0x00, SUB 0x01, AND 0x02, OR 0x03: Ra ← Rb op Rc.
  - MUL 0x0E, DIV 0x0F: HI:LO ← Ra op Rb.
  - NOP 0x18, HALT 0x19.
  - Any other opcode: executes as NOP and sets illegal.
- States: IDLE, T0, T1, WAIT, T2, T3, T4, T5, T6.
- Outputs are combinational from state, decoded ir and mem_ready. Every signal not listed for a state is 0; BusDataSelect and GP_addr hold 0 when unused.
- IDLE: all enables 0. Go to T0 when start=1.
- T0: Bus=PC (10100), e_MAR, incPC, e_Z. → T1.
- T1: Bus=Zlow, e_PC, MDR_read, e_MDR=mem_ready. → T2 if mem_ready, else WAIT.
- WAIT: MDR_read, e_MDR=mem_ready; e_PC=0. → T2 on mem_ready, otherwise stay.
- T2: Bus=MDR, e_IR. → T3.
- T3:
  - ALU class: Bus=Rb, e_Y.
  - MUL/DIV: Bus=Ra, e_Y.
  - NOP/illegal: no enables; retire, → T0.
  - HALT: done=1; retire, → IDLE.
- T4:
  - ALU class: Bus=Rc, ALU_op per opcode, e_Z.
  - MUL/DIV: Bus=Rb, ALU_op per opcode, e_Z.
- T5:
  - ALU class: Bus=Zlow, GP_addr=Ra, e_GP; retire, → T0.
  - MUL/DIV: Bus=Zlow, e_LO.
- T6 (MUL/DIV only): Bus=Zhigh, e_HI; retire, → T0.
- Retire: instr_count increments by 1 on the clock edge leaving the final state.
- ALU_op holds its per-opcode value during T4 only.

## Timing
- Reset: state IDLE. All outputs 0, including instr_count and illegal. Takes effect immediately on clear falling, including mid-instruction; no partial completion.
- With zero wait states: ALU class = 6 cycles, MUL/DIV = 7 cycles, NOP/illegal = 4 cycles, HALT = 4 cycles ending in IDLE.
- Each WAIT cycle adds 1 cycle. mem_ready already high in T1 → no WAIT.
- start is ignored outside IDLE. start held high after HALT restarts fetch on the next cycle.
- e_PC is asserted exactly once per fetch, regardless of wait states.

## Configuration
- MDU_SEQ_SINGLE_STEP_EN:
  - Defined: every retire (not only HALT) goes to IDLE and pulses done. Each instruction needs a new start.
  - Undefined: free-run from T0 until HALT.

## Test plan
- Reset mid-T4 of an ADD → all enables 0 the same cycle, state IDLE, instr_count 0; after release, start → T0 with Bus=10100.
- ir = DIV R2,R6 (op 0x0F, Ra=2, Rb=6), mem_ready=1 → T3 Bus=00010 e_Y; T4 Bus=00110 ALU_op=0110 e_Z; T5 Bus=10011 e_LO; T6 Bus=10010 e_HI; instr_count=1 after 7 cycles.
- ADD R1,R2,R3 → T5 Bus=10011 GP_addr=0001 e_GP; 6 cycles.
- mem_ready low for 3 cycles in T1 → 3 WAIT cycles; e_PC asserted 1 cycle only; e_MDR asserted only on the mem_ready cycle.
- Opcode 0x1F → illegal=1 (sticky), 4-cycle NOP, fetch continues; HALT then yields done=1 for 1 cycle and busy=0.
- Single-step build: MUL then ADD with start pulsed once → stops in IDLE after MUL with done=1; second start executes ADD.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Control-step sequencer for the single-bus CPU datapath: fetch (T0-T2, WAIT) then execute.
// Build option MDU_SEQ_SINGLE_STEP_EN: every retired instruction returns to IDLE and pulses done.
module mdu_sequencer #(
    parameter int OPW  = 5,
    parameter int CNTW = 16
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            start,
    input  logic            mem_ready,
    input  logic [31:0]     ir,
    output logic [4:0]      BusDataSelect,
    output logic [3:0]      GP_addr,
    output logic [3:0]      ALU_op,
    output logic            e_PC,
    output logic            e_IR,
    output logic            e_Y,
    output logic            e_Z,
    output logic            e_HI,
    output logic            e_LO,
    output logic            e_MDR,
    output logic            e_MAR,
    output logic            e_GP,
    output logic            incPC,
    output logic            MDR_read,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic [CNTW-1:0] instr_count
);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(8'h00);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(8'h01);
    localparam logic [OPW-1:0] OP_AND  = OPW'(8'h02);
    localparam logic [OPW-1:0] OP_OR   = OPW'(8'h03);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(8'h0E);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(8'h0F);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(8'h18);
    localparam logic [OPW-1:0] OP_HALT = OPW'(8'h19);

    localparam logic [4:0] BUS_ZHI = 5'b10010;
    localparam logic [4:0] BUS_ZLO = 5'b10011;
    localparam logic [4:0] BUS_PC  = 5'b10100;
    localparam logic [4:0] BUS_MDR = 5'b10101;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_WAIT, S_T2, S_T3, S_T4, S_T5, S_T6
    } state_t;

    state_t state, next;

    logic [OPW-1:0] op;
    logic [3:0]     ra, rb, rc;
    logic           is_alu, is_md, is_halt, is_ill;
    logic [3:0]     alu_code;
    logic           retire;

    assign op = ir[31 -: OPW];
    assign ra = ir[26:23];
    assign rb = ir[22:19];
    assign rc = ir[18:15];

    // Immediate/unused IR bits carry no control meaning for this sequencer.
    logic unused_ir;
    assign unused_ir = ^ir[14:0];

    always_comb begin
        is_alu  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
        is_md   = (op == OP_MUL) || (op == OP_DIV);
        is_halt = (op == OP_HALT);
        is_ill  = !(is_alu || is_md || is_halt || (op == OP_NOP));
        case (op)
            OP_SUB:  alu_code = 4'b0001;
            OP_AND:  alu_code = 4'b0010;
            OP_OR:   alu_code = 4'b0011;
            OP_MUL:  alu_code = 4'b0101;
            OP_DIV:  alu_code = 4'b0110;
            default: alu_code = 4'b0000;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_comb begin
        next          = state;
        BusDataSelect = '0;
        GP_addr       = '0;
        ALU_op        = '0;
        e_PC          = 1'b0;
        e_IR          = 1'b0;
        e_Y           = 1'b0;
        e_Z           = 1'b0;
        e_HI          = 1'b0;
        e_LO          = 1'b0;
        e_MDR         = 1'b0;
        e_MAR         = 1'b0;
        e_GP          = 1'b0;
        incPC         = 1'b0;
        MDR_read      = 1'b0;
        done          = 1'b0;
        retire        = 1'b0;
        case (state)
            S_IDLE: if (start) next = S_T0;
            S_T0: begin
                BusDataSelect = BUS_PC;
                e_MAR = 1'b1;
                incPC = 1'b1;
                e_Z   = 1'b1;
                next  = S_T1;
            end
            // PC is loaded here only, so extra WAIT cycles never re-increment it.
            S_T1: begin
                BusDataSelect = BUS_ZLO;
                e_PC     = 1'b1;
                MDR_read = 1'b1;
                e_MDR    = mem_ready;
                next     = mem_ready ? S_T2 : S_WAIT;
            end
            S_WAIT: begin
                MDR_read = 1'b1;
                e_MDR    = mem_ready;
                if (mem_ready) next = S_T2;
            end
            S_T2: begin
                BusDataSelect = BUS_MDR;
                e_IR = 1'b1;
                next = S_T3;
            end
            S_T3: begin
                if (is_alu || is_md) begin
                    BusDataSelect = {1'b0, is_alu ? rb : ra};
                    e_Y  = 1'b1;
                    next = S_T4;
                end else begin
                    retire = 1'b1;
                end
            end
            S_T4: begin
                BusDataSelect = {1'b0, is_alu ? rc : rb};
                ALU_op = alu_code;
                e_Z    = 1'b1;
                next   = S_T5;
            end
            S_T5: begin
                BusDataSelect = BUS_ZLO;
                if (is_alu) begin
                    GP_addr = ra;
                    e_GP    = 1'b1;
                    retire  = 1'b1;
                end else begin
                    e_LO = 1'b1;
                    next = S_T6;
                end
            end
            S_T6: begin
                BusDataSelect = BUS_ZHI;
                e_HI   = 1'b1;
                retire = 1'b1;
            end
            default: next = S_IDLE;
        endcase
        if (retire) begin
`ifdef MDU_SEQ_SINGLE_STEP_EN
            next = S_IDLE;
            done = 1'b1;
`else
            next = is_halt ? S_IDLE : S_T0;
            done = is_halt;
`endif
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= S_IDLE;
            instr_count <= '0;
            illegal     <= 1'b0;
        end else begin
            state <= next;
            if (retire) instr_count <= instr_count + CNTW'(1);
            if (state == S_T3 && is_ill) illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized self-checking bench for mdu_sequencer against a per-instruction step-list model.
// Honors MDU_SEQ_SINGLE_STEP_EN in the model when the design is built with it.
module tb_mdu_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] ir = '0;
    logic [4:0]  BusDataSelect;
    logic [3:0]  GP_addr, ALU_op;
    logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
    logic        incPC, MDR_read, busy, done, illegal;
    logic [15:0] instr_count;

    always #5 clock = ~clock;

    mdu_sequencer #(.OPW(5), .CNTW(16)) dut (
        .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
        .BusDataSelect(BusDataSelect), .GP_addr(GP_addr), .ALU_op(ALU_op),
        .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI), .e_LO(e_LO),
        .e_MDR(e_MDR), .e_MAR(e_MAR), .e_GP(e_GP), .incPC(incPC), .MDR_read(MDR_read),
        .busy(busy), .done(done), .illegal(illegal), .instr_count(instr_count)
    );

`ifdef MDU_SEQ_SINGLE_STEP_EN
    localparam bit SS = 1'b1;
`else
    localparam bit SS = 1'b0;
`endif

    // Control vector: {bus, gp_addr, alu_op, flags}
    typedef logic [25:0] ctl_t;
    localparam logic [12:0] F_PC = 13'h1000, F_IR = 13'h0800, F_Y = 13'h0400, F_Z = 13'h0200;
    localparam logic [12:0] F_HI = 13'h0100, F_LO = 13'h0080, F_MDR = 13'h0040, F_MAR = 13'h0020;
    localparam logic [12:0] F_GP = 13'h0010, F_INC = 13'h0008, F_RD = 13'h0004, F_BUSY = 13'h0002;
    localparam logic [12:0] F_DONE = 13'h0001;

    int checks = 0;
    int errors = 0;

    ctl_t        exp_q[$];
    bit          mr_q[$], st_q[$], ret_q[$], ill_q[$];
    logic [31:0] ir_q[$];
    bit          at_idle = 1'b1;
    logic [15:0] m_count = '0;
    bit          m_ill = 1'b0;

    function automatic ctl_t obs();
        return {BusDataSelect, GP_addr, ALU_op, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO,
                e_MDR, e_MAR, e_GP, incPC, MDR_read, busy, done};
    endfunction

    function automatic ctl_t mk(input logic [4:0] b, input logic [3:0] g,
                                input logic [3:0] a, input logic [12:0] f);
        return {b, g, a, f};
    endfunction

    function automatic bit rnd();
        return ($urandom & 1) != 0;
    endfunction

    function automatic logic [31:0] ins(input logic [4:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c, 15'($urandom)};
    endfunction

    task automatic clear_q();
        exp_q.delete(); mr_q.delete(); st_q.delete(); ret_q.delete(); ill_q.delete(); ir_q.delete();
    endtask

    task automatic push(input ctl_t c, input bit mr, input bit st, input logic [31:0] iv,
                        input bit ret, input bit il);
        exp_q.push_back(c); mr_q.push_back(mr); st_q.push_back(st);
        ir_q.push_back(iv); ret_q.push_back(ret); ill_q.push_back(il);
    endtask

    task automatic add_idle(input bit st, input logic [31:0] iv);
        push('0, rnd(), st, iv, 1'b0, 1'b0);
        if (st) at_idle = 1'b0;
    endtask

    // Reference model: the step list of one instruction, straight from the instruction classes.
    task automatic add_instr(input logic [31:0] iv, input int waits);
        logic [4:0]  op = iv[31:27];
        logic [3:0]  ra = iv[26:23], rb = iv[22:19], rc = iv[18:15];
        bit          alu = (op <= 5'd3);
        bit          md = (op == 5'd14) || (op == 5'd15);
        bit          halt = (op == 5'd25);
        bit          il = !(alu || md || halt || op == 5'd24);
        logic [3:0]  code = (op == 5'd14) ? 4'd5 : (op == 5'd15) ? 4'd6 : {2'b00, op[1:0]};
        logic [12:0] dn = SS ? F_DONE : 13'h0;
        if (at_idle) add_idle(1'b1, iv);
        push(mk(5'b10100, 0, 0, F_MAR | F_INC | F_Z | F_BUSY), rnd(), rnd(), iv, 0, 0);
        push(mk(5'b10011, 0, 0, F_PC | F_RD | F_BUSY | (waits == 0 ? F_MDR : 13'h0)),
             waits == 0, rnd(), iv, 0, 0);
        for (int k = 1; k <= waits; k++)
            push(mk(0, 0, 0, F_RD | F_BUSY | (k == waits ? F_MDR : 13'h0)), k == waits, rnd(), iv, 0, 0);
        push(mk(5'b10101, 0, 0, F_IR | F_BUSY), rnd(), rnd(), iv, 0, 0);
        if (alu) begin
            push(mk({1'b0, rb}, 0, 0, F_Y | F_BUSY), rnd(), rnd(), iv, 0, 0);
            push(mk({1'b0, rc}, 0, code, F_Z | F_BUSY), rnd(), rnd(), iv, 0, 0);
            push(mk(5'b10011, ra, 0, F_GP | F_BUSY | dn), rnd(), rnd(), iv, 1, 0);
        end else if (md) begin
            push(mk({1'b0, ra}, 0, 0, F_Y | F_BUSY), rnd(), rnd(), iv, 0, 0);
            push(mk({1'b0, rb}, 0, code, F_Z | F_BUSY), rnd(), rnd(), iv, 0, 0);
            push(mk(5'b10011, 0, 0, F_LO | F_BUSY), rnd(), rnd(), iv, 0, 0);
            push(mk(5'b10010, 0, 0, F_HI | F_BUSY | dn), rnd(), rnd(), iv, 1, 0);
        end else begin
            push(mk(0, 0, 0, F_BUSY | (halt ? F_DONE : dn)), rnd(), rnd(), iv, 1, il);
        end
        at_idle = SS || halt;
    endtask

    // Drive cycle i of the queue (called just after a rising edge) and sample at the falling edge.
    task automatic sample(input int i, output ctl_t o, output logic [15:0] c, output logic l);
        ir = ir_q[i]; mem_ready = mr_q[i]; start = st_q[i];
        @(negedge clock);
        o = obs(); c = instr_count; l = illegal;
    endtask

    task automatic advance(input int i);
        @(posedge clock); #1;
        if (ret_q[i]) m_count = m_count + 16'd1;
        if (ill_q[i]) m_ill = 1'b1;
    endtask

    task automatic test_reset();
        clear = 1'b1; #2; clear = 1'b0; #2;
        checks++;
        if (obs() !== '0) begin errors++; $display("FAIL reset_ctl: got %h want 0", obs()); end
        checks++;
        if (instr_count !== 16'd0 || illegal !== 1'b0) begin
            errors++; $display("FAIL reset_state: got cnt=%0d ill=%b want 0/0", instr_count, illegal);
        end
        start = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (busy !== 1'b0 || BusDataSelect !== 5'd0) begin
            errors++; $display("FAIL reset_hold: got busy=%b bus=%b want 0/00000", busy, BusDataSelect);
        end
        start = 1'b0; clear = 1'b1;
        at_idle = 1'b1; m_count = '0; m_ill = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_alu_class();
        ctl_t o; logic [15:0] c; logic l;
        clear_q();
        add_instr({5'd0, 4'd1, 4'd2, 4'd3, 15'd0}, 0);
        add_instr(ins(5'd1, 4'd4, 4'd5, 4'd6), 0);
        add_instr(ins(5'd2, 4'd7, 4'd8, 4'd9), 0);
        add_instr(ins(5'd3, 4'd15, 4'd0, 4'd14), 0);
        add_instr(ins(5'd25, 0, 0, 0), 0);
        add_idle(1'b0, '0);
        for (int i = 0; i < exp_q.size(); i++) begin
            sample(i, o, c, l); checks++;
            if ({o, c, l} !== {exp_q[i], m_count, m_ill}) begin
                errors++;
                $display("FAIL alu_class cyc %0d: got ctl=%h cnt=%0d ill=%b want ctl=%h cnt=%0d ill=%b",
                         i, o, c, l, exp_q[i], m_count, m_ill);
            end
            advance(i);
        end
    endtask

    task automatic test_muldiv();
        ctl_t o; logic [15:0] c; logic l;
        clear_q();
        add_instr({5'd15, 4'd2, 4'd6, 4'd0, 15'd0}, 0);
        add_instr(ins(5'd14, 4'd9, 4'd10, 4'd3), 0);
        add_instr(ins(5'd25, 0, 0, 0), 0);
        add_idle(1'b0, '0);
        for (int i = 0; i < exp_q.size(); i++) begin
            sample(i, o, c, l); checks++;
            if ({o, c, l} !== {exp_q[i], m_count, m_ill}) begin
                errors++;
                $display("FAIL muldiv cyc %0d: got ctl=%h cnt=%0d ill=%b want ctl=%h cnt=%0d ill=%b",
                         i, o, c, l, exp_q[i], m_count, m_ill);
            end
            advance(i);
        end
    endtask

    task automatic test_wait_states();
        ctl_t o; logic [15:0] c; logic l;
        clear_q();
        add_instr(ins(5'd0, 4'd1, 4'd2, 4'd3), 3);
        add_instr(ins(5'd24, 0, 0, 0), 1);
        add_instr(ins(5'd25, 0, 0, 0), 2);
        add_idle(1'b0, '0);
        for (int i = 0; i < exp_q.size(); i++) begin
            sample(i, o, c, l); checks++;
            if ({o, c, l} !== {exp_q[i], m_count, m_ill}) begin
                errors++;
                $display("FAIL wait_states cyc %0d: got ctl=%h cnt=%0d ill=%b want ctl=%h cnt=%0d ill=%b",
                         i, o, c, l, exp_q[i], m_count, m_ill);
            end
            advance(i);
        end
    endtask

    task automatic test_illegal();
        ctl_t o; logic [15:0] c; logic l;
        clear_q();
        add_instr(ins(5'h1F, 4'd3, 4'd4, 4'd5), 0);
        add_instr(ins(5'd0, 4'd6, 4'd7, 4'd8), 0);
        add_instr(ins(5'd25, 0, 0, 0), 0);
        add_idle(1'b0, '0);
        for (int i = 0; i < exp_q.size(); i++) begin
            sample(i, o, c, l); checks++;
            if ({o, c, l} !== {exp_q[i], m_count, m_ill}) begin
                errors++;
                $display("FAIL illegal cyc %0d: got ctl=%h cnt=%0d ill=%b want ctl=%h cnt=%0d ill=%b",
                         i, o, c, l, exp_q[i], m_count, m_ill);
            end
            advance(i);
        end
    endtask

    task automatic test_back_to_back();
        ctl_t o; logic [15:0] c; logic l;
        clear_q();
`ifdef MDU_SEQ_SINGLE_STEP_EN
        add_instr(ins(5'd14, 4'd1, 4'd2, 4'd0), 0);
        add_idle(1'b0, '0);
        add_idle(1'b0, '0);
        add_instr(ins(5'd0, 4'd3, 4'd4, 4'd5), 0);
`else
        add_instr(ins(5'd25, 0, 0, 0), 0);
        add_instr(ins(5'd0, 4'd3, 4'd4, 4'd5), 1);
        add_instr(ins(5'd25, 0, 0, 0), 0);
`endif
        add_idle(1'b0, '0);
        for (int i = 0; i < exp_q.size(); i++) begin
            sample(i, o, c, l); checks++;
            if ({o, c, l} !== {exp_q[i], m_count, m_ill}) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: got ctl=%h cnt=%0d ill=%b want ctl=%h cnt=%0d ill=%b",
                         i, o, c, l, exp_q[i], m_count, m_ill);
            end
            advance(i);
        end
    endtask

    task automatic test_random();
        ctl_t o; logic [15:0] c; logic l;
        logic [4:0] op;
        clear_q();
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 9: op = 5'($urandom_range(0, 3));
                4: op = 5'd14;
                5: op = 5'd15;
                6: op = 5'd24;
                7: op = 5'($urandom_range(16, 23));
                default: op = 5'($urandom_range(0, 31));
            endcase
            add_instr(ins(op, 4'($urandom), 4'($urandom), 4'($urandom)), $urandom_range(0, 3));
        end
        add_instr(ins(5'd25, 0, 0, 0), 0);
        add_idle(1'b0, '0);
        for (int i = 0; i < exp_q.size(); i++) begin
            sample(i, o, c, l); checks++;
            if ({o, c, l} !== {exp_q[i], m_count, m_ill}) begin
                errors++;
                $display("FAIL random cyc %0d: got ctl=%h cnt=%0d ill=%b want ctl=%h cnt=%0d ill=%b",
                         i, o, c, l, exp_q[i], m_count, m_ill);
            end
            advance(i);
        end
    endtask

    task automatic test_reset_mid();
        ctl_t o; logic [15:0] c; logic l;
        clear_q();
        add_instr({5'd0, 4'd1, 4'd2, 4'd3, 15'd0}, 0);
        // Entries 0..5 are IDLE(start), T0, T1, T2, T3, T4; reset lands inside T4.
        for (int i = 0; i < 6; i++) begin
            sample(i, o, c, l); checks++;
            if ({o, c, l} !== {exp_q[i], m_count, m_ill}) begin
                errors++;
                $display("FAIL reset_mid cyc %0d: got ctl=%h cnt=%0d ill=%b want ctl=%h cnt=%0d ill=%b",
                         i, o, c, l, exp_q[i], m_count, m_ill);
            end
            if (i < 5) advance(i);
        end
        #2 clear = 1'b0; #1;
        checks++;
        if ({obs(), instr_count, illegal} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got ctl=%h cnt=%0d ill=%b want all 0", obs(), instr_count, illegal);
        end
        @(posedge clock); #1;
        clear = 1'b1;
        at_idle = 1'b1; m_count = '0; m_ill = 1'b0;
        clear_q();
        add_instr({5'd0, 4'd1, 4'd2, 4'd3, 15'd0}, 0);
        add_instr(ins(5'd25, 0, 0, 0), 0);
        add_idle(1'b0, '0);
        for (int i = 0; i < exp_q.size(); i++) begin
            sample(i, o, c, l); checks++;
            if ({o, c, l} !== {exp_q[i], m_count, m_ill}) begin
                errors++;
                $display("FAIL reset_mid_restart cyc %0d: got ctl=%h cnt=%0d ill=%b want ctl=%h cnt=%0d ill=%b",
                         i, o, c, l, exp_q[i], m_count, m_ill);
            end
            advance(i);
        end
    endtask

    initial begin
        test_reset();
        test_alu_class();
        test_muldiv();
        test_wait_states();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
